// File: rtl/sort_datapath.sv
// Sort datapath: K-entry array, index counters i/j, operand registers A/B, host load port
// and a valid/ready unload stream. Define SORT_DESCENDING_EN to flip AgtB for descending order.
module sort_datapath #(
  parameter  int K  = 8,
  parameter  int N  = 8,
  localparam int AW = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Wr,
  input  logic          Li,
  input  logic          Ei,
  input  logic          Lj,
  input  logic          Ej,
  input  logic          EA,
  input  logic          EB,
  input  logic          Bout,
  input  logic          Csel,
  input  logic          done,
  output logic          AgtB,
  output logic          zi,
  output logic          zj,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [N-1:0]  host_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_last,
  output logic          unloading
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    UNLOAD = 1'b1
  } state_t;

  logic [N-1:0]  mem_r [K];
  logic [AW-1:0] i_r;
  logic [AW-1:0] j_r;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [AW-1:0] ptr_r;
  logic [AW-1:0] ptr_next_s;
  state_t        state_r;
  state_t        state_next_s;

  logic [AW-1:0] addr_s;
  logic [N-1:0]  rdata_s;
  logic [N-1:0]  wdata_s;
  logic          xfer_s;
  logic          ptr_last_s;

  // Indices are only meaningful below K; non-power-of-two K leaves a gap in the index space.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return ({1'b0, idx} < (AW+1)'(K));
  endfunction

  // Operand address, combinational array read and write-data mux.
  always_comb begin
    addr_s  = Csel ? j_r : i_r;
    wdata_s = Bout ? b_r : a_r;
    if (idx_ok(addr_s)) begin
      rdata_s = mem_r[addr_s];
    end else begin
      rdata_s = {N{1'b0}};
    end
  end

  // Array storage: controller write wins over the host port; host writes are blocked while unloading.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < K; k++) begin
        mem_r[k] <= {N{1'b0}};
      end
    end else if (Wr) begin
      if (idx_ok(addr_s)) begin
        mem_r[addr_s] <= wdata_s;
      end
    end else if (host_we && (state_r == IDLE) && idx_ok(host_addr)) begin
      mem_r[host_addr] <= host_wdata;
    end
  end

  // Counter i: load-to-zero has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_r <= {AW{1'b0}};
    end else if (Li) begin
      i_r <= {AW{1'b0}};
    end else if (Ei) begin
      i_r <= i_r + AW'(1);
    end
  end

  // Counter j: Lj alone copies i, Lj with Ej starts one past i.
  always_ff @(posedge clk) begin
    if (rst) begin
      j_r <= {AW{1'b0}};
    end else if (Lj && Ej) begin
      j_r <= i_r + AW'(1);
    end else if (Lj) begin
      j_r <= i_r;
    end else if (Ej) begin
      j_r <= j_r + AW'(1);
    end
  end

  // Operand registers capture the current array read.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= {N{1'b0}};
      b_r <= {N{1'b0}};
    end else begin
      if (EA) begin
        a_r <= rdata_s;
      end
      if (EB) begin
        b_r <= rdata_s;
      end
    end
  end

  // Status flags back to the controller.
  always_comb begin
`ifdef SORT_DESCENDING_EN
    AgtB = (a_r < b_r);
`else
    AgtB = (a_r > b_r);
`endif
    zi = (i_r == AW'(K-2));
    zj = (j_r == AW'(K-1));
  end

  // Unload FSM state and read pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= {AW{1'b0}};
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
    end
  end

  // Unload FSM next state: done is only heard in IDLE.
  always_comb begin
    ptr_last_s   = (ptr_r == AW'(K-1));
    xfer_s       = (state_r == UNLOAD) && out_ready;
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (done) begin
          state_next_s = UNLOAD;
          ptr_next_s   = {AW{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      UNLOAD: begin
        if (xfer_s && ptr_last_s) begin
          state_next_s = IDLE;
          ptr_next_s   = {AW{1'b0}};
        end else if (xfer_s) begin
          ptr_next_s   = ptr_r + AW'(1);
        end else begin
          state_next_s = UNLOAD;
        end
      end
      default: begin
        state_next_s = IDLE;
        ptr_next_s   = {AW{1'b0}};
      end
    endcase
  end

  // Unload FSM outputs; the pointer is a register so out_data holds while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    unloading = 1'b0;
    out_data  = {N{1'b0}};
    case (state_r)
      UNLOAD: begin
        out_valid = 1'b1;
        out_last  = ptr_last_s;
        unloading = 1'b1;
        if (idx_ok(ptr_r)) begin
          out_data = mem_r[ptr_r];
        end else begin
          out_data = {N{1'b0}};
        end
      end
      IDLE: begin
        out_valid = 1'b0;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sort_datapath.sv
// Scoreboard bench for sort_datapath: directed strobe sequences, a reference sort controller,
// and a monitor that checks the unload stream against queued expectations.
module tb_sort_datapath;
  localparam int K  = 8;
  localparam int N  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, Wr, Li, Ei, Lj, Ej, EA, EB, Bout, Csel, done;
  logic AgtB, zi, zj;
  logic host_we;
  logic [AW-1:0] host_addr;
  logic [N-1:0] host_wdata;
  logic out_valid, out_ready, out_last, unloading;
  logic [N-1:0] out_data;

  typedef struct packed {
    logic [N-1:0] data;
    logic         last;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic stall_prev = 1'b0;
  logic [N-1:0] held = 8'd0;

  sort_datapath #(.K(K), .N(N)) dut (
    .clk(clk), .rst(rst), .Wr(Wr), .Li(Li), .Ei(Ei), .Lj(Lj), .Ej(Ej),
    .EA(EA), .EB(EB), .Bout(Bout), .Csel(Csel), .done(done),
    .AgtB(AgtB), .zi(zi), .zj(zj),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .unloading(unloading)
  );

  // Monitor: pops the scoreboard on each transfer and checks stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        checks++;
        if (out_data !== held) begin
          errors++;
          $display("FAIL stall_hold got %0d want %0d", out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer got data %0d last %0d want none", out_data, out_last);
        end else begin
          e = expq.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL stream_elem got %0d/%0d want %0d/%0d", out_data, out_last, e.data, e.last);
          end
        end
        xfers++;
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
    end
  end

  task automatic clr();
    Wr = 1'b0; Li = 1'b0; Ei = 1'b0; Lj = 1'b0; Ej = 1'b0;
    EA = 1'b0; EB = 1'b0; Bout = 1'b0; Csel = 1'b0; done = 1'b0;
    host_we = 1'b0; host_addr = 3'd0; host_wdata = 8'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic hwrite(input logic [AW-1:0] a, input logic [N-1:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
  endtask

  task automatic push_stream(input logic [N-1:0] v [K], input int cnt);
    for (int k = 0; k < cnt; k++) begin
      expq.push_back('{data: v[k], last: (k == K-1)});
    end
  endtask

  // Pulse done and run the stream to completion; bp applies a 1,0,0,1 ready pattern plus
  // a host write and a second done pulse while unloading.
  task automatic unload_and_check(input int nexp, input logic bp);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    xfers = 0;
    out_ready = 1'b1;
    done = 1'b1;
    step();
    n = 0;
    while (unloading && n < 100) begin
      out_ready = (bp && n < 4) ? pat[3-n] : 1'b1;
      if (bp && n == 1) begin
        host_we = 1'b1; host_addr = 3'd7; host_wdata = 8'd123;
        done = 1'b1;
      end
      step();
      n++;
    end
    check("stream_end", {31'd0, unloading}, 32'd0);
    check("xfer_count", xfers, nexp);
    check("queue_empty", expq.size(), 32'd0);
    step();
    check("no_restart", {31'd0, unloading}, 32'd0);
  endtask

  // Reference controller: exchange sort over i < j using the datapath strobes.
  task automatic sort_ctrl();
    logic last_i, last_j;
    int guard;
    guard = 0;
    Li = 1'b1; step();
    do begin
      Lj = 1'b1; Ej = 1'b1; step();
      do begin
        EA = 1'b1; Csel = 1'b0; step();
        EB = 1'b1; Csel = 1'b1; step();
        if (AgtB) begin
          Wr = 1'b1; Bout = 1'b1; Csel = 1'b0; step();
          Wr = 1'b1; Bout = 1'b0; Csel = 1'b1; step();
        end
        last_j = zj;
        if (!last_j) begin
          Ej = 1'b1; step();
        end
        guard++;
      end while (!last_j && guard < 200);
      last_i = zi;
      if (!last_i) begin
        Ei = 1'b1; step();
      end
    end while (!last_i && guard < 200);
  endtask

  logic [N-1:0] swap_exp [K];
  logic [N-1:0] init_v   [K];
  logic [N-1:0] sort_exp [K];
  logic [N-1:0] zero_v   [K];

  initial begin
    swap_exp = '{8'd4, 8'd9, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    init_v   = '{8'd7, 8'd3, 8'd200, 8'd0, 8'd3, 8'd255, 8'd1, 8'd9};
`ifdef SORT_DESCENDING_EN
    sort_exp = '{8'd255, 8'd200, 8'd9, 8'd7, 8'd3, 8'd3, 8'd1, 8'd0};
`else
    sort_exp = '{8'd0, 8'd1, 8'd3, 8'd3, 8'd7, 8'd9, 8'd200, 8'd255};
`endif
    zero_v   = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    clr();
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_unloading", {31'd0, unloading}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_agtb", {31'd0, AgtB}, 32'd0);
    check("rst_zi", {31'd0, zi}, 32'd0);
    check("rst_zj", {31'd0, zj}, 32'd0);

    // Counter semantics
    Li = 1'b1; Ei = 1'b1; step();
    for (int k = 0; k < 3; k++) begin Ei = 1'b1; step(); end
    Lj = 1'b1; Ej = 1'b1; step();
    check("cnt_zi_i3", {31'd0, zi}, 32'd0);
    check("cnt_zj_j4", {31'd0, zj}, 32'd0);
    for (int k = 0; k < 3; k++) begin Ei = 1'b1; step(); end
    check("cnt_zi_i6", {31'd0, zi}, 32'd1);
    Lj = 1'b1; step();
    check("cnt_zj_j6", {31'd0, zj}, 32'd0);
    Ej = 1'b1; step();
    check("cnt_zj_j7", {31'd0, zj}, 32'd1);
    for (int k = 0; k < 8; k++) begin Ei = 1'b1; step(); end
    check("cnt_i_wrap", {31'd0, zi}, 32'd1);

    // Swap sequence, then controller-vs-host priority on mem[2]
    hwrite(3'd0, 8'd9);
    hwrite(3'd1, 8'd4);
    Li = 1'b1; step();
    Lj = 1'b1; Ej = 1'b1; step();
    EA = 1'b1; Csel = 1'b0; step();
    EB = 1'b1; Csel = 1'b1; step();
`ifdef SORT_DESCENDING_EN
    check("swap_agtb", {31'd0, AgtB}, 32'd0);
`else
    check("swap_agtb", {31'd0, AgtB}, 32'd1);
`endif
    Wr = 1'b1; Bout = 1'b1; Csel = 1'b0; step();
    Wr = 1'b1; Bout = 1'b0; Csel = 1'b1; step();
    Ej = 1'b1; step();
    Wr = 1'b1; Bout = 1'b1; Csel = 1'b1;
    host_we = 1'b1; host_addr = 3'd2; host_wdata = 8'd77;
    step();
    push_stream(swap_exp, K);
    unload_and_check(K, 1'b0);

    // Full sort with backpressure and ignored host_we/done during unload
    for (int k = 0; k < K; k++) hwrite(AW'(k), init_v[k]);
    sort_ctrl();
    push_stream(sort_exp, K);
    unload_and_check(K, 1'b1);

    // Reset after three transfers
    xfers = 0;
    push_stream(sort_exp, 3);
    out_ready = 1'b1;
    done = 1'b1;
    step();
    step(); step(); step();
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_unloading", {31'd0, unloading}, 32'd0);
    check("mid_rst_xfers", xfers, 32'd3);
    check("mid_rst_queue", expq.size(), 32'd0);
    check("mid_rst_zj", {31'd0, zj}, 32'd0);
    for (int k = 0; k < 6; k++) begin Ei = 1'b1; step(); end
    check("mid_rst_i0", {31'd0, zi}, 32'd1);
    for (int k = 0; k < 7; k++) begin Ej = 1'b1; step(); end
    check("mid_rst_j0", {31'd0, zj}, 32'd1);
    push_stream(zero_v, K);
    unload_and_check(K, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
